proc_controller: RTL and testbench
==================================

Name: proc_controller

Overview:
- Multi-cycle control unit for the 16-bit processor datapath (synchronous-read data memory feeding a 16x16 register file through the RF write mux, plus the ALU).
- Owns the program counter (PC) and instruction register (IR). Fetches from a synchronous-read instruction ROM.
- Decodes one instruction at a time and sequences D_Addr/D_Wr, register-file addresses and enables, the RF_s mux select and the ALU select.

Parameters:
- PC_W, 7: instruction ROM address width; the PC wraps modulo 2^PC_W.
- DA_W, 8: data memory address width; fixed by the instruction format, and only the default is supported.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- I_data  input  16  instruction ROM read data; valid one cycle after PC_Addr.
- PC_Addr  output  PC_W  instruction ROM address, equal to the PC register.
- IR_Out  output  16  current IR contents.
- D_Addr  output  DA_W  data memory address.
- D_Wr  output  1  data memory write enable.
- RF_s  output  1  RF write-data select: 1 = data memory R_data, 0 = ALU result.
- RF_W_en  output  1  register file write enable.
- RF_W_Addr  output  4  register file write address.
- RF_Ra_Addr  output  4  register file read port A address.
- RF_Rb_Addr  output  4  register file read port B address.
- ALU_s0  output  3  ALU function: 000 = pass A, 001 = add, 010 = subtract.
- Halted  output  1  high while in HALT.
- State_Out  output  4  current state encoding, for the board display.

Behaviour:
- Clock and reset: single clock domain, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: state = INIT, PC = 0, IR = 0. All outputs are 0 except State_Out = 0.
- Instruction format (opcode = IR[15:12]):
  - NOOP 0000.
  - STORE 0001: D[IR[7:0]] <= RF[IR[11:8]].
  - LOAD 0010: RF[IR[3:0]] <= D[IR[11:4]].
  - ADD 0011: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
  - SUB 0100: RF[IR[3:0]] <= RF[IR[11:8]] - RF[IR[7:4]].
  - HALT 0101.
  - Opcodes 0110-1111 execute as NOOP.
- States and encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Transitions:
  - INIT -> FETCH. PC is cleared in INIT.
  - FETCH: IR <= I_data; PC <= PC + 1, wrapping 2^PC_W-1 -> 0. Next state DECODE.
  - DECODE: branch on opcode to NOOP, STORE, LOAD_A, ADD, SUB or HALT.
  - NOOP, STORE, LOAD_B, ADD and SUB each return to FETCH. LOAD_A -> LOAD_B.
  - HALT is absorbing; only Reset_n leaves it.
- Per-state outputs (Moore, decoded from registered state and IR). Default for every output is 0.
  - LOAD_A: D_Addr = IR[11:4], RF_s = 1. Memory read is in flight.
  - LOAD_B: D_Addr = IR[11:4], RF_s = 1, RF_W_Addr = IR[3:0], RF_W_en = 1.
  - STORE: D_Addr = IR[7:0], RF_Ra_Addr = IR[11:8], D_Wr = 1.
  - ADD: RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0], ALU_s0 = 001, RF_W_en = 1.
  - SUB: same as ADD except ALU_s0 = 010.
  - HALT: Halted = 1.
- Write pulses: D_Wr and RF_W_en are asserted for exactly one cycle per instruction and never in FETCH, DECODE, NOOP, LOAD_A or HALT.
- Latency: NOOP, STORE, ADD and SUB take 3 cycles. LOAD takes 4 cycles. HALT takes 3 cycles to reach the HALT state.
- ROM timing: PC is stable for at least 2 cycles before every FETCH, so I_data always corresponds to the current PC. No ROM wait state is needed.
- Same-register operands: Ra = Rb = Rd is legal. The register file writes on the cycle-ending edge, so reads in that cycle see old data.
- Reset mid-instruction: takes effect immediately and asynchronously. Any in-flight write enable drops the same instant and no partial write completes. Execution restarts at PC = 0.
- IR is only written in FETCH. PC is only written in INIT, FETCH and reset.

Test Plan:
- Reset sequence: reset, release, ROM[0] = 0x0000 (NOOP). Required: State_Out 0,1,2,3,1; PC_Addr 0 -> 1 on the FETCH edge; all enables 0 throughout.
- LOAD: ROM[0] = 0x2053. Required: LOAD_A then LOAD_B with D_Addr = 0x05 in both; RF_s = 1 in both; RF_W_en = 1 and RF_W_Addr = 3 only in LOAD_B. Total 4 cycles from FETCH.
- STORE: ROM[1] = 0x1A2C. Required: one D_Wr pulse with D_Addr = 0x2C and RF_Ra_Addr = 0xA. RF_W_en stays 0.
- ADD and SUB: ROM = 0x3127, 0x4127. Required: Ra = 1, Rb = 2, Rd = 7; ALU_s0 = 001 then 010; RF_s = 0; one RF_W_en pulse each.
- HALT, illegal opcode and PC wrap:
  - ROM[2] = 0xF000 executes as NOOP.
  - ROM[3] = 0x5000 holds HALT with Halted = 1 and PC_Addr = 4 for 20 cycles.
  - Separately, 128 NOOPs wrap PC_Addr 127 -> 0.
- Reset during LOAD_B: assert Reset_n = 0 mid-cycle. Required: RF_W_en falls immediately; after release the sequence resumes at INIT with PC_Addr = 0.

Source files
------------

// File: rtl/proc_controller.sv
// Multi-cycle control unit: owns PC and IR, fetches from a synchronous ROM and
// sequences data-memory, register-file and ALU controls one instruction at a time.
module proc_controller #(
    parameter int PC_W = 7,
    parameter int DA_W = 8
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] PC_Addr,
    output logic [15:0]     IR_Out,
    output logic [DA_W-1:0] D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_Addr,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      State_Out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     ir_nxt;

    logic [7:0] d_addr_nxt;
    logic       d_wr_nxt, rf_s_nxt, rf_w_en_nxt, halted_nxt;
    logic [3:0] rf_w_addr_nxt, rf_ra_addr_nxt, rf_rb_addr_nxt;
    logic [2:0] alu_s0_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC_Addr;
        ir_nxt    = IR_Out;
        case (state)
            S_INIT: begin
                pc_nxt    = '0;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_nxt    = I_data;
                pc_nxt    = PC_Addr + PC_W'(1);
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (IR_Out[15:12])
                    4'b0001: state_nxt = S_STORE;
                    4'b0010: state_nxt = S_LOAD_A;
                    4'b0011: state_nxt = S_ADD;
                    4'b0100: state_nxt = S_SUB;
                    4'b0101: state_nxt = S_HALT;
                    default: state_nxt = S_NOOP;
                endcase
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Outputs are decoded from the upcoming state/IR so that the registered
    // copies line up with the state they belong to.
    always_comb begin
        d_addr_nxt     = '0;
        d_wr_nxt       = 1'b0;
        rf_s_nxt       = 1'b0;
        rf_w_en_nxt    = 1'b0;
        rf_w_addr_nxt  = '0;
        rf_ra_addr_nxt = '0;
        rf_rb_addr_nxt = '0;
        alu_s0_nxt     = 3'b000;
        halted_nxt     = 1'b0;
        case (state_nxt)
            S_LOAD_A: begin
                d_addr_nxt = ir_nxt[11:4];
                rf_s_nxt   = 1'b1;
            end
            S_LOAD_B: begin
                d_addr_nxt    = ir_nxt[11:4];
                rf_s_nxt      = 1'b1;
                rf_w_addr_nxt = ir_nxt[3:0];
                rf_w_en_nxt   = 1'b1;
            end
            S_STORE: begin
                d_addr_nxt     = ir_nxt[7:0];
                rf_ra_addr_nxt = ir_nxt[11:8];
                d_wr_nxt       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_nxt = ir_nxt[11:8];
                rf_rb_addr_nxt = ir_nxt[7:4];
                rf_w_addr_nxt  = ir_nxt[3:0];
                rf_w_en_nxt    = 1'b1;
                alu_s0_nxt     = (state_nxt == S_ADD) ? 3'b001 : 3'b010;
            end
            S_HALT: halted_nxt = 1'b1;
            default: ;
        endcase
    end

    // Asynchronous reset clears every registered output, so an in-flight write
    // enable drops the instant Reset_n falls.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_INIT;
            PC_Addr    <= '0;
            IR_Out     <= '0;
            D_Addr     <= '0;
            D_Wr       <= 1'b0;
            RF_s       <= 1'b0;
            RF_W_en    <= 1'b0;
            RF_W_Addr  <= '0;
            RF_Ra_Addr <= '0;
            RF_Rb_Addr <= '0;
            ALU_s0     <= 3'b000;
            Halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            PC_Addr    <= pc_nxt;
            IR_Out     <= ir_nxt;
            D_Addr     <= DA_W'(d_addr_nxt);
            D_Wr       <= d_wr_nxt;
            RF_s       <= rf_s_nxt;
            RF_W_en    <= rf_w_en_nxt;
            RF_W_Addr  <= rf_w_addr_nxt;
            RF_Ra_Addr <= rf_ra_addr_nxt;
            RF_Rb_Addr <= rf_rb_addr_nxt;
            ALU_s0     <= alu_s0_nxt;
            Halted     <= halted_nxt;
        end
    end

    assign State_Out = state;

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller: ROM programs expanded by an instruction-level model
// into an expected per-cycle trace, compared against the DUT on falling edges.
module tb_proc_controller;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] I_data;
    logic [6:0]  PC_Addr;
    logic [15:0] IR_Out;
    logic [7:0]  D_Addr;
    logic        D_Wr, RF_s, RF_W_en, Halted;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State_Out;
    logic [2:0]  ALU_s0;

    proc_controller #(.PC_W(7), .DA_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .I_data(I_data),
        .PC_Addr(PC_Addr), .IR_Out(IR_Out), .D_Addr(D_Addr), .D_Wr(D_Wr),
        .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_Addr(RF_W_Addr),
        .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0),
        .Halted(Halted), .State_Out(State_Out)
    );

    always #5 Clk = ~Clk;

    logic [15:0] rom [128];
    always @(posedge Clk) I_data <= rom[PC_Addr];

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dwr;
        logic        rfs;
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halt;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs, exp_r;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    function automatic rec_t mk(input int st, input int pc, input logic [15:0] ir);
        rec_t r;
        r    = '0;
        r.st = st[3:0];
        r.pc = pc[6:0];
        r.ir = ir;
        return r;
    endfunction

    function automatic rec_t observe();
        rec_t r;
        r.st = State_Out; r.pc = PC_Addr; r.ir = IR_Out; r.da = D_Addr;
        r.dwr = D_Wr; r.rfs = RF_s; r.wen = RF_W_en; r.wa = RF_W_Addr;
        r.ra = RF_Ra_Addr; r.rb = RF_Rb_Addr; r.alu = ALU_s0; r.halt = Halted;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("st=%0d pc=%0d ir=%h da=%h dwr=%b rfs=%b wen=%b wa=%h ra=%h rb=%h alu=%0d halt=%b",
                         r.st, r.pc, r.ir, r.da, r.dwr, r.rfs, r.wen, r.wa, r.ra, r.rb, r.alu, r.halt);
    endfunction

    // Instruction-level model: walk the ROM from PC 0 and emit n cycles of
    // expected outputs (INIT, then FETCH/DECODE/execute per instruction).
    task automatic gen_expected(input int n);
        int          pc;
        logic [15:0] ir;
        logic [3:0]  op;
        rec_t        r;
        exp_q.delete();
        pc = 0;
        ir = '0;
        exp_q.push_back(mk(0, pc, ir));
        while (exp_q.size() < n) begin
            exp_q.push_back(mk(1, pc, ir));
            ir = rom[pc];
            pc = (pc + 1) % 128;
            exp_q.push_back(mk(2, pc, ir));
            op = ir[15:12];
            case (op)
                4'd1: begin
                    r = mk(6, pc, ir); r.da = ir[7:0]; r.ra = ir[11:8]; r.dwr = 1'b1;
                    exp_q.push_back(r);
                end
                4'd2: begin
                    r = mk(4, pc, ir); r.da = ir[11:4]; r.rfs = 1'b1;
                    exp_q.push_back(r);
                    r.st = 4'd5; r.wa = ir[3:0]; r.wen = 1'b1;
                    exp_q.push_back(r);
                end
                4'd3, 4'd4: begin
                    r = mk((op == 4'd3) ? 7 : 8, pc, ir);
                    r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0]; r.wen = 1'b1;
                    r.alu = (op == 4'd3) ? 3'd1 : 3'd2;
                    exp_q.push_back(r);
                end
                4'd5: begin
                    r = mk(9, pc, ir); r.halt = 1'b1;
                    while (exp_q.size() < n) exp_q.push_back(r);
                end
                default: exp_q.push_back(mk(3, pc, ir));
            endcase
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Leaves Reset_n released on a falling edge; DUT is in INIT until the next rise.
    task automatic apply_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        obs = observe();
        chk_cnt++;
        if (obs !== mk(0, 0, 16'h0)) $display("FAIL reset_hold: got %s, expected %s", fmt(obs), fmt(mk(0, 0, 16'h0)));
        else pass_cnt++;
        @(negedge Clk);
        Reset_n = 1'b1;
        gen_expected(8);
        for (int i = 0; i < 8; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL reset_seq cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_load();
        clear_rom();
        rom[0] = 16'h2053;
        apply_reset();
        gen_expected(10);
        for (int i = 0; i < 10; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL load cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_store();
        clear_rom();
        rom[1] = 16'h1A2C;
        apply_reset();
        gen_expected(12);
        for (int i = 0; i < 12; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL store cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_alu();
        clear_rom();
        rom[0] = 16'h3127;
        rom[1] = 16'h4127;
        rom[2] = 16'h3555;
        apply_reset();
        gen_expected(14);
        for (int i = 0; i < 14; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL alu cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_halt();
        clear_rom();
        rom[2] = 16'hF000;
        rom[3] = 16'h5000;
        rom[4] = 16'h3127;
        apply_reset();
        gen_expected(35);
        for (int i = 0; i < 35; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL halt cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_wrap();
        clear_rom();
        apply_reset();
        gen_expected(1 + 130 * 3);
        for (int i = 0; i < 1 + 130 * 3; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL wrap cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_random();
        clear_rom();
        for (int i = 0; i < 50; i++) begin
            rom[i] = 16'($urandom_range(0, 65535));
            if (rom[i][15:12] == 4'd5) rom[i][15:12] = 4'd2;
        end
        apply_reset();
        gen_expected(200);
        for (int i = 0; i < 200; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL random cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom[0] = 16'h2053;
        rom[1] = 16'h3127;
        apply_reset();
        gen_expected(5);
        for (int i = 0; i < 5; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL reset_mid_pre cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            if (i < 4) @(negedge Clk);
        end
        #2 Reset_n = 1'b0;
        #1;
        obs = observe();
        chk_cnt++;
        if (obs !== mk(0, 0, 16'h0)) $display("FAIL reset_mid_drop: got %s, expected %s", fmt(obs), fmt(mk(0, 0, 16'h0)));
        else pass_cnt++;
        @(negedge Clk);
        Reset_n = 1'b1;
        gen_expected(12);
        for (int i = 0; i < 12; i++) begin
            exp_r = exp_q.pop_front();
            obs = observe();
            chk_cnt++;
            if (obs !== exp_r) $display("FAIL reset_mid_resume cycle %0d: got %s, expected %s", i, fmt(obs), fmt(exp_r));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_halt();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
